// File: rtl/state_sequencer.sv
// Multicycle CPU state sequencer: steps FETCH/DECODE/EXEC1/EXEC2/MDWAIT,
// honours Avalon waitrequest stalls, retires instructions and trips a watchdog.
module state_sequencer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             div_mult_en,
  input  logic             md_done,
  input  logic             pc_next_zero,
  output logic [3:0]       state,
  output logic             active,
  output logic             stall,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int SC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_HALT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC1  = 4'd3,
    S_EXEC2  = 4'd4,
    S_MDWAIT = 4'd5
  } state_e;

  state_e            state_r;
  state_e            seq_next_s;
  state_e            next_state_s;
  logic              bad_enc_s;
  logic              timeout_s;
  logic              retire_s;
  logic [SC_W-1:0]   stall_cnt_r;

  // Nominal next state from the control-unit handshakes.
  always_comb begin
    seq_next_s = state_r;
    bad_enc_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (memread && waitrequest) seq_next_s = S_FETCH;
        else                        seq_next_s = S_DECODE;
      end
      S_DECODE: seq_next_s = S_EXEC1;
      S_EXEC1: begin
        if (memread && waitrequest) seq_next_s = S_EXEC1;
        else if (div_mult_en)       seq_next_s = S_MDWAIT;
        else                        seq_next_s = S_EXEC2;
      end
      S_MDWAIT: begin
        if (md_done) seq_next_s = S_EXEC2;
        else         seq_next_s = S_MDWAIT;
      end
      S_EXEC2: begin
        // Never leave EXEC2 while memory stalls, so the exit edge is the pcwrite edge.
        if (waitrequest)       seq_next_s = S_EXEC2;
        else if (pc_next_zero) seq_next_s = S_HALT;
        else                   seq_next_s = S_FETCH;
      end
      S_HALT: seq_next_s = S_HALT;
      default: begin
        seq_next_s = S_HALT;
        bad_enc_s  = 1'b1;
      end
    endcase
  end

  // Watchdog override, stall flag and retire detection.
  always_comb begin
    timeout_s = (stall_cnt_r == SC_W'(TIMEOUT)) && (state_r != S_HALT);
    if (timeout_s) begin
      next_state_s = S_HALT;
    end else begin
      next_state_s = seq_next_s;
    end
    // Gated by reset so the flag reads low while reset is asserted.
    stall    = reset && (state_r != S_HALT) && (next_state_s == state_r);
    retire_s = (state_r == S_EXEC2) && (next_state_s != S_EXEC2);
  end

  // Sequencer state, registered status outputs and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_FETCH;
      active      <= 1'b1;
      fault       <= 1'b0;
      instr_count <= {CNT_W{1'b0}};
      stall_cnt_r <= {SC_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      active  <= (next_state_s != S_HALT);
      if (timeout_s || bad_enc_s) begin
        fault <= 1'b1;
      end
      if (retire_s) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (stall) begin
        stall_cnt_r <= stall_cnt_r + SC_W'(1);
      end else begin
        stall_cnt_r <= {SC_W{1'b0}};
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: directed per-cycle vectors push expected
// observations into a queue; a negedge monitor pops and compares.
module tb_state_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic       act;
    logic       stl;
    logic       flt;
    logic [3:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       waitrequest, memread, memwrite, div_mult_en, md_done, pc_next_zero;
  logic [3:0] state;
  logic       active, stall, fault;
  logic [3:0] instr_count;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  state_sequencer #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .memread(memread),
    .memwrite(memwrite), .div_mult_en(div_mult_en), .md_done(md_done),
    .pc_next_zero(pc_next_zero), .state(state), .active(active), .stall(stall),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Monitor: compares every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t g;
      e = exp_q.pop_front();
      g = '{st: state, act: active, stl: stall, flt: fault, cnt: instr_count};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL cycle_obs#%0d: got st=%0d act=%0b stall=%0b fault=%0b cnt=%0d, required st=%0d act=%0b stall=%0b fault=%0b cnt=%0d",
                 tests, g.st, g.act, g.stl, g.flt, g.cnt, e.st, e.act, e.stl, e.flt, e.cnt);
      end
    end
  end

  // One clock cycle: drive inputs, record expected observation, advance past the edge.
  task automatic cyc(input logic mr, input logic mw, input logic wr, input logic dm,
                     input logic md, input logic pz, input logic [3:0] es,
                     input logic estl, input logic ef, input logic [3:0] ec);
    memread = mr; memwrite = mw; waitrequest = wr;
    div_mult_en = dm; md_done = md; pc_next_zero = pz;
    exp_q.push_back('{st: es, act: (es != 4'd0), stl: estl, flt: ef, cnt: ec});
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset for one cycle with stall-provoking inputs applied.
  task automatic do_reset();
    reset = 1'b0;
    memread = 1'b1; waitrequest = 1'b1; memwrite = 1'b0;
    div_mult_en = 1'b0; md_done = 1'b0; pc_next_zero = 1'b0;
    exp_q.push_back('{st: 4'd1, act: 1'b1, stl: 1'b0, flt: 1'b0, cnt: 4'd0});
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic addiu(input logic [3:0] c);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, c);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, c);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, c);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, c);
  endtask

  initial begin
    reset = 1'b0;
    memread = 1'b0; memwrite = 1'b0; waitrequest = 1'b0;
    div_mult_en = 1'b0; md_done = 1'b0; pc_next_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // No-wait ADDIU: 1,2,3,4 then FETCH with one retired.
    addiu(4'd0);

    // LW with a 3-cycle EXEC1 stall; DECODE ignores waitrequest.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 4'd1);

    // SW: EXEC2 holds on waitrequest with memwrite high and low.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 4'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 4'd2);

    // Multiply: md_done outside MDWAIT ignored; MDWAIT present 5 cycles.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 4'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd3);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 4'd3);

    // Halt via pc_next_zero; retirement counted; HALT absorbs all inputs.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 4'd4);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5);

    // Watchdog: 8 stall cycles in FETCH, then HALT with fault.
    do_reset();
    repeat (8) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);

    // Reset clears fault; then reset abandons an instruction in MDWAIT.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0);
    do_reset();

    // 16 instructions wrap the 4-bit count back to 0.
    for (int k = 0; k < 16; k++) begin
      addiu(4'(k));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd0);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: maximum consecutive stall cycles before a fault.
REQ-002 SHALL have parameter CNT_W, default 32: width of instr_count.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 waitrequest  input  1  Avalon stall from memory.
REQ-007 memread  input  1  control-unit read request for the current state.
REQ-008 memwrite  input  1  control-unit write request for the current state.
REQ-009 div_mult_en  input  1  control-unit multiply/divide start, valid in EXEC1.
REQ-010 md_done  input  1  multiply/divide result ready pulse.
REQ-011 pc_next_zero  input  1  next PC equals 0x00000000, meaning a return to address 0 and halt.
REQ-012 state  output  4  sequencer state: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2, 5 MDWAIT.
REQ-013 active  output  1  high while the CPU is executing.
REQ-014 stall  output  1  high in any cycle where state is held waiting.
REQ-015 fault  output  1  sticky watchdog timeout flag.
REQ-016 instr_count  output  CNT_W  count of retired instructions.

Function
REQ-017 FETCH SHALL hold while memread & waitrequest, and otherwise go to DECODE next cycle.
REQ-018 DECODE SHALL always go to EXEC1 next cycle, ignoring waitrequest.
REQ-019 EXEC1 transitions, in priority order:
- memread & waitrequest: hold.
- div_mult_en: go to MDWAIT.
- otherwise: go to EXEC2.
REQ-020 MDWAIT SHALL hold while !md_done and go to EXEC2 on md_done; md_done SHALL be sampled only in MDWAIT.
REQ-021 EXEC2 transitions, in priority order:
- memwrite & waitrequest: hold.
- !waitrequest & pc_next_zero: go to HALT.
- !waitrequest: go to FETCH.
- waitrequest with memwrite low: hold.
REQ-022 HALT SHALL be absorbing until reset, and all inputs SHALL be ignored in HALT.
REQ-023 Encodings 6-15 SHALL go to HALT on the next edge with fault set.
REQ-024 stall SHALL be combinational and high exactly when the next state equals the current state, in any state except HALT.
REQ-025 A stall counter SHALL:
- increment on each stall cycle;
- clear on every cycle where the state changes.
REQ-026 When the stall counter reaches TIMEOUT, the next state SHALL be HALT with fault=1, overriding REQ-017 to REQ-021.
REQ-027 instr_count SHALL increment by 1 on each edge that leaves EXEC2, including the edge into HALT, and SHALL wrap modulo 2^CNT_W.
REQ-028 active SHALL be registered, equal to (state != HALT), and change on the same edge as state.
REQ-029 The control unit's pcwrite (exec2 & !waitrequest) SHALL coincide with the EXEC2 exit edge; the sequencer SHALL never leave EXEC2 while waitrequest is high.

Reset
REQ-030 When reset is low, the block SHALL asynchronously force:
- state = FETCH (1), active = 1, stall = 0, fault = 0;
- instr_count = 0, stall counter = 0.
REQ-031 Reset asserted mid-instruction, in any state including HALT or MDWAIT, SHALL abandon the instruction without incrementing instr_count.
REQ-032 After reset deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-033 No-wait ADDIU: waitrequest=0, memread=1 only in FETCH -> states 1,2,3,4,1 on successive edges; instr_count=1 after the 4th edge.
REQ-034 LW with 3-cycle stall: memread=1, waitrequest=1 for 3 cycles in EXEC1 -> EXEC1 held 3 cycles with stall=1, then EXEC2; 7 edges fetch-to-fetch.
REQ-035 Multiply: div_mult_en=1 in EXEC1, md_done after 5 cycles -> MDWAIT held 5 cycles, then EXEC2, then FETCH; instr_count +1.
REQ-036 Halt: JR to 0 with pc_next_zero=1 and waitrequest=0 in EXEC2 -> state 0, active=0 next edge; later inputs have no effect.
REQ-037 Watchdog: TIMEOUT=8, waitrequest held high in FETCH -> after 8 stall cycles state=0, fault=1, active=0.
REQ-038 Reset mid-MDWAIT, and instr_count at 2^CNT_W-1 retiring one instruction -> immediate state=1, count=0; wrap-around to 0.
